// File: rtl/psum_drain.sv
// Drains skewed per-column partial sums from a systolic array into aligned,
// width-converted rows, one drain job of ROWS rows per start pulse.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; inputs ignored, FIFOs hold their state
// COLLECT | columns write their FIFOs; aligned rows pop when all ready
// DONE    | one-cycle job-complete pulse, then back to IDLE
module psum_drain #(
  parameter int N         = 4,
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 16,
  parameter int SIGNED    = 0,
  parameter int DEPTH     = 4,
  parameter int ROWS      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N-1:0]           in_valid,
  input  logic [N*WIDTH_IN-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*WIDTH_OUT-1:0] out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [RW-1:0] row_cnt;
  logic [N-1:0]  empty;
  logic [N-1:0]  full;
  logic [N-1:0]  drop;
  logic          collect;
  logic          flush;
  logic          pop;
  logic          last_row;

  assign collect   = (state == COLLECT);
  assign flush     = (state == IDLE) && start;
  assign out_valid = collect && (&(~empty));
  assign pop       = out_valid && out_ready;
  assign last_row  = (row_cnt == RW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = COLLECT;
      end
      COLLECT: begin
        busy = 1'b1;
        if (pop && last_row) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush)  row_cnt <= '0;
    else if (pop)      row_cnt <= last_row ? '0 : row_cnt + RW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) overflow <= 1'b0;
    else if (|drop)   overflow <= 1'b1;
  end

  for (genvar c = 0; c < N; c++) begin : g_col
    logic [WIDTH_IN-1:0]  mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [WIDTH_IN-1:0]  head;
    logic [WIDTH_OUT-1:0] conv;
    logic                 wr_en;

    assign empty[c] = (wr_ptr == rd_ptr);
    assign full[c]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A full column may still accept a write in a cycle that pops its head.
    assign wr_en    = collect && in_valid[c] && (!full[c] || pop);
    assign drop[c]  = collect && in_valid[c] && full[c] && !pop;
    assign head     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= in_data[c*WIDTH_IN +: WIDTH_IN];
    end

    if (WIDTH_OUT < WIDTH_IN) begin : g_narrow
      if (SIGNED != 0) begin : g_sat_s
        localparam logic [WIDTH_OUT-1:0] SMAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
        localparam logic [WIDTH_OUT-1:0] SMIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};
        logic [WIDTH_IN-WIDTH_OUT:0] top;
        // In range only when every bit above the output sign bit matches it.
        assign top  = head[WIDTH_IN-1:WIDTH_OUT-1];
        assign conv = ((top == '0) || (&top)) ? head[WIDTH_OUT-1:0]
                    : (head[WIDTH_IN-1] ? SMIN : SMAX);
      end else begin : g_sat_u
        assign conv = (|head[WIDTH_IN-1:WIDTH_OUT]) ? '1 : head[WIDTH_OUT-1:0];
      end
    end else begin : g_wide
      if (SIGNED != 0) begin : g_ext_s
        assign conv = WIDTH_OUT'($signed(head));
      end else begin : g_ext_u
        assign conv = WIDTH_OUT'(head);
      end
    end

    assign out_data[c*WIDTH_OUT +: WIDTH_OUT] = conv;
  end

endmodule
